// File: rtl/hazard_ctrl.sv
// Hazard/bypass controller: forwarding selects, load-use and long-latency scoreboard stalls,
// multi-cycle branch flush window. Define HAZARD_PERF_EN to add stall/flush event counters.
module hazard_ctrl #(
    parameter int FWD_STAGES = 2,
    parameter int BR_FLUSH   = 2,
    parameter int MAX_LL     = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [4:0]                        i_id_rs1,
    input  logic [4:0]                        i_id_rs2,
    input  logic                              i_id_use1,
    input  logic                              i_id_use2,
    input  logic                              i_id_is_ll,
    input  logic                              i_ex_valid,
    input  logic [4:0]                        i_ex_rd,
    input  logic                              i_ex_is_load,
    input  logic [4:0]                        i_ex_rs1,
    input  logic [4:0]                        i_ex_rs2,
    input  logic [FWD_STAGES-1:0]             i_fwd_we,
    input  logic [5*FWD_STAGES-1:0]           i_fwd_rd,
    input  logic                              i_ll_issue,
    input  logic [4:0]                        i_ll_rd,
    input  logic                              i_ll_done,
    input  logic [4:0]                        i_ll_done_rd,
    input  logic                              i_mem_busy,
    input  logic                              i_br_taken,
    output logic [$clog2(FWD_STAGES+1)-1:0]   o_fwd_sel_a,
    output logic [$clog2(FWD_STAGES+1)-1:0]   o_fwd_sel_b,
    output logic                              o_stall_front,
    output logic                              o_bubble_ex,
    output logic                              o_freeze,
    output logic                              o_flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                       o_stall_cycles,
    output logic [31:0]                       o_flush_events
`endif
);

    localparam int SW = $clog2(FWD_STAGES + 1);
    localparam int FW = (BR_FLUSH > 1) ? $clog2(BR_FLUSH) : 1;
    localparam int CW = $clog2(MAX_LL + 1);

    logic [31:0]   pend;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;
    logic [CW-1:0] ll_cnt;
    logic [FW-1:0] fcnt;
    logic [SW-1:0] sel_a;
    logic [SW-1:0] sel_b;
    logic          load_use;
    logic          sb_haz;
    logic          cap_full;
    logic          hazard;
    logic          window;
    logic          done_eff;

    // Scan from the oldest source down so the youngest matching source is written last.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = FWD_STAGES; i > 0; i--) begin
            if (i_fwd_we[i-1] && i_fwd_rd[5*(i-1) +: 5] == i_ex_rs1 && i_ex_rs1 != '0)
                sel_a = SW'(i);
            if (i_fwd_we[i-1] && i_fwd_rd[5*(i-1) +: 5] == i_ex_rs2 && i_ex_rs2 != '0)
                sel_b = SW'(i);
        end
    end

    always_comb begin
        load_use = i_ex_valid && i_ex_is_load && i_ex_rd != '0 &&
                   ((i_id_use1 && i_id_rs1 == i_ex_rd) || (i_id_use2 && i_id_rs2 == i_ex_rd));
        sb_haz   = (i_id_use1 && i_id_rs1 != '0 &&
                    (pend[i_id_rs1] || (i_ll_issue && i_ll_rd == i_id_rs1))) ||
                   (i_id_use2 && i_id_rs2 != '0 &&
                    (pend[i_id_rs2] || (i_ll_issue && i_ll_rd == i_id_rs2)));
        cap_full = i_id_is_ll && ll_cnt == CW'(MAX_LL) && !i_ll_done;
        hazard   = load_use || sb_haz || cap_full;
        window   = i_br_taken || fcnt != '0;
        done_eff = i_ll_done && ll_cnt != '0;
        set_vec  = (i_ll_issue && i_ll_rd != '0) ? (32'd1 << i_ll_rd) : '0;
        clr_vec  = i_ll_done ? (32'd1 << i_ll_done_rd) : '0;
    end

    // Freeze outranks flush, which outranks stall; everything is quiet during reset.
    always_comb begin
        o_fwd_sel_a   = i_rst ? '0 : sel_a;
        o_fwd_sel_b   = i_rst ? '0 : sel_b;
        o_freeze      = !i_rst && i_mem_busy;
        o_flush       = !i_rst && !i_mem_busy && window;
        o_stall_front = !i_rst && !i_mem_busy && !window && hazard;
        o_bubble_ex   = o_stall_front;
    end

    // Set after clear so a same-cycle re-issue of the retiring register stays pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend   <= '0;
            ll_cnt <= '0;
        end else begin
            pend <= (pend & ~clr_vec) | set_vec;
            if (i_ll_issue && !done_eff && ll_cnt != CW'(MAX_LL))
                ll_cnt <= ll_cnt + 1'b1;
            else if (!i_ll_issue && done_eff)
                ll_cnt <= ll_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            fcnt <= '0;
        else if (!i_mem_busy) begin
            if (i_br_taken)
                fcnt <= FW'(BR_FLUSH - 1);
            else if (fcnt != '0)
                fcnt <= fcnt - 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else begin
            if (o_stall_front && !o_freeze)
                o_stall_cycles <= o_stall_cycles + 32'd1;
            if (i_br_taken)
                o_flush_events <= o_flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected outputs queued per step, popped and asserted
// just after the inputs settle, before the next rising edge.
module tb_hazard_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [4:0] i_id_rs1, i_id_rs2;
    logic       i_id_use1, i_id_use2, i_id_is_ll;
    logic       i_ex_valid;
    logic [4:0] i_ex_rd;
    logic       i_ex_is_load;
    logic [4:0] i_ex_rs1, i_ex_rs2;
    logic [1:0] i_fwd_we;
    logic [9:0] i_fwd_rd;
    logic       i_ll_issue;
    logic [4:0] i_ll_rd;
    logic       i_ll_done;
    logic [4:0] i_ll_done_rd;
    logic       i_mem_busy, i_br_taken;
    logic [1:0] o_fwd_sel_a, o_fwd_sel_b;
    logic       o_stall_front, o_bubble_ex, o_freeze, o_flush;

    typedef struct packed {
        logic [1:0] sa;
        logic [1:0] sb;
        logic       st;
        logic       bu;
        logic       fr;
        logic       fl;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    hazard_ctrl #(.FWD_STAGES(2), .BR_FLUSH(2), .MAX_LL(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_use1(i_id_use1), .i_id_use2(i_id_use2), .i_id_is_ll(i_id_is_ll),
        .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load),
        .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
        .i_fwd_we(i_fwd_we), .i_fwd_rd(i_fwd_rd),
        .i_ll_issue(i_ll_issue), .i_ll_rd(i_ll_rd),
        .i_ll_done(i_ll_done), .i_ll_done_rd(i_ll_done_rd),
        .i_mem_busy(i_mem_busy), .i_br_taken(i_br_taken),
        .o_fwd_sel_a(o_fwd_sel_a), .o_fwd_sel_b(o_fwd_sel_b),
        .o_stall_front(o_stall_front), .o_bubble_ex(o_bubble_ex),
        .o_freeze(o_freeze), .o_flush(o_flush)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t mk(input logic [1:0] sa, input logic [1:0] sb,
                                input logic st, input logic fr, input logic fl);
        exp_t e;
        e.sa = sa; e.sb = sb; e.st = st; e.bu = st; e.fr = fr; e.fl = fl;
        return e;
    endfunction

    task automatic idle();
        i_rst = 1'b0;
        i_id_rs1 = '0; i_id_rs2 = '0; i_id_use1 = 1'b0; i_id_use2 = 1'b0; i_id_is_ll = 1'b0;
        i_ex_valid = 1'b0; i_ex_rd = '0; i_ex_is_load = 1'b0; i_ex_rs1 = '0; i_ex_rs2 = '0;
        i_fwd_we = '0; i_fwd_rd = '0;
        i_ll_issue = 1'b0; i_ll_rd = '0; i_ll_done = 1'b0; i_ll_done_rd = '0;
        i_mem_busy = 1'b0; i_br_taken = 1'b0;
    endtask

    // Queue the expectation, compare once the combinational outputs settle, then advance a cycle.
    task automatic step(input string tag, input exp_t e);
        exp_t want;
        exp_t got;
        exp_q.push_back(e);
        #1;
        got  = {o_fwd_sel_a, o_fwd_sel_b, o_stall_front, o_bubble_ex, o_freeze, o_flush};
        want = exp_q.pop_front();
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s observed=%b expected=%b (sa,sb,stall,bubble,freeze,flush)",
                    tag, got, want);
        @(negedge i_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        // Reset with active-looking inputs: every output must stay low.
        i_rst = 1'b1; i_mem_busy = 1'b1; i_br_taken = 1'b1;
        i_fwd_we = 2'b11; i_fwd_rd = {5'd5, 5'd5}; i_ex_rs1 = 5'd5;
        step("reset_outputs", mk(0, 0, 0, 0, 0));
        idle();
        step("post_reset_clean", mk(0, 0, 0, 0, 0));

        // Forwarding
        i_fwd_we = 2'b11; i_fwd_rd = {5'd5, 5'd5}; i_ex_rs1 = 5'd5;
        step("fwd_youngest", mk(1, 0, 0, 0, 0));
        i_ex_rs1 = 5'd0;
        step("fwd_x0", mk(0, 0, 0, 0, 0));
        i_fwd_rd = {5'd5, 5'd6}; i_ex_rs1 = 5'd5; i_ex_rs2 = 5'd6;
        step("fwd_src1_a_src0_b", mk(2, 1, 0, 0, 0));
        i_fwd_we = 2'b10; i_fwd_rd = {5'd5, 5'd5}; i_ex_rs1 = 5'd3; i_ex_rs2 = 5'd5;
        step("fwd_we_mask", mk(0, 2, 0, 0, 0));
        idle();

        // Load-use
        i_ex_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_rd = 5'd7; i_id_rs2 = 5'd7; i_id_use2 = 1'b1;
        step("lu_rs2", mk(0, 0, 1, 0, 0));
        i_id_use2 = 1'b0;
        step("lu_nouse", mk(0, 0, 0, 0, 0));
        i_ex_rd = 5'd0; i_id_rs2 = 5'd0; i_id_use2 = 1'b1;
        step("lu_x0", mk(0, 0, 0, 0, 0));
        i_ex_rd = 5'd8; i_id_rs1 = 5'd8; i_id_use1 = 1'b1; i_id_use2 = 1'b0; i_ex_valid = 1'b0;
        step("lu_invalid", mk(0, 0, 0, 0, 0));
        idle();

        // Scoreboard: issue rd 9 with an immediate consumer
        i_ll_issue = 1'b1; i_ll_rd = 5'd9; i_id_rs1 = 5'd9; i_id_use1 = 1'b1;
        step("sb_same_cycle", mk(0, 0, 1, 0, 0));
        i_ll_issue = 1'b0;
        step("sb_pend1", mk(0, 0, 1, 0, 0));
        step("sb_pend2", mk(0, 0, 1, 0, 0));
        i_ll_done = 1'b1; i_ll_done_rd = 5'd9;
        step("sb_done_cycle", mk(0, 0, 1, 0, 0));
        i_ll_done = 1'b0;
        step("sb_released", mk(0, 0, 0, 0, 0));
        idle();
        i_ll_issue = 1'b1; i_ll_rd = 5'd9; i_ll_done = 1'b1; i_ll_done_rd = 5'd9;
        step("sb_issue_done", mk(0, 0, 0, 0, 0));
        idle();
        i_id_rs1 = 5'd9; i_id_use1 = 1'b1;
        step("sb_younger_wins", mk(0, 0, 1, 0, 0));
        i_id_use1 = 1'b0;
        step("sb_unused_rs", mk(0, 0, 0, 0, 0));
        i_ll_done = 1'b1; i_ll_done_rd = 5'd9;
        step("sb_clear9", mk(0, 0, 0, 0, 0));
        idle();
        i_id_rs1 = 5'd9; i_id_use1 = 1'b1;
        step("sb_clear9_free", mk(0, 0, 0, 0, 0));
        idle();

        // Outstanding limit
        for (int r = 10; r < 14; r++) begin
            i_ll_issue = 1'b1; i_ll_rd = 5'(r);
            step("ll_issue_fill", mk(0, 0, 0, 0, 0));
        end
        idle();
        i_id_is_ll = 1'b1;
        step("ll_full_stall", mk(0, 0, 1, 0, 0));
        i_ll_done = 1'b1; i_ll_done_rd = 5'd10;
        step("ll_full_done_same", mk(0, 0, 0, 0, 0));
        i_ll_done = 1'b0;
        step("ll_count3", mk(0, 0, 0, 0, 0));
        idle();
        for (int r = 11; r < 14; r++) begin
            i_ll_done = 1'b1; i_ll_done_rd = 5'(r);
            step("ll_drain", mk(0, 0, 0, 0, 0));
        end
        i_ll_done_rd = 5'd1;
        step("ll_done_at_zero", mk(0, 0, 0, 0, 0));
        idle();
        for (int r = 14; r < 18; r++) begin
            i_ll_issue = 1'b1; i_ll_rd = 5'(r);
            step("ll_refill", mk(0, 0, 0, 0, 0));
        end
        idle();
        i_id_is_ll = 1'b1;
        step("ll_sat_zero_full", mk(0, 0, 1, 0, 0));
        idle();
        for (int r = 14; r < 18; r++) begin
            i_ll_done = 1'b1; i_ll_done_rd = 5'(r);
            step("ll_drain2", mk(0, 0, 0, 0, 0));
        end
        idle();

        // Flush window
        i_br_taken = 1'b1;
        step("br_t", mk(0, 0, 0, 0, 1));
        i_br_taken = 1'b0;
        step("br_t1", mk(0, 0, 0, 0, 1));
        step("br_t2_clear", mk(0, 0, 0, 0, 0));
        i_br_taken = 1'b1;
        step("br2_t", mk(0, 0, 0, 0, 1));
        step("br2_t1_reload", mk(0, 0, 0, 0, 1));
        i_br_taken = 1'b0;
        step("br2_t2", mk(0, 0, 0, 0, 1));
        step("br2_t3_clear", mk(0, 0, 0, 0, 0));
        i_br_taken = 1'b1;
        i_ex_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_rd = 5'd7; i_id_rs1 = 5'd7; i_id_use1 = 1'b1;
        step("br_lu_suppr0", mk(0, 0, 0, 0, 1));
        i_br_taken = 1'b0;
        step("br_lu_suppr1", mk(0, 0, 0, 0, 1));
        step("br_lu_after", mk(0, 0, 1, 0, 0));
        idle();

        // Freeze inside the flush window
        i_br_taken = 1'b1;
        step("frz_br", mk(0, 0, 0, 0, 1));
        i_br_taken = 1'b0; i_mem_busy = 1'b1;
        step("frz_1", mk(0, 0, 0, 1, 0));
        i_ll_issue = 1'b1; i_ll_rd = 5'd20;
        step("frz_2_issue", mk(0, 0, 0, 1, 0));
        i_ll_issue = 1'b0;
        i_ex_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_rd = 5'd7; i_id_rs2 = 5'd7; i_id_use2 = 1'b1;
        step("frz_3_lu_masked", mk(0, 0, 0, 1, 0));
        idle();
        step("frz_resume_flush", mk(0, 0, 0, 0, 1));
        i_id_rs1 = 5'd20; i_id_use1 = 1'b1;
        step("frz_sb_updated", mk(0, 0, 1, 0, 0));
        idle();
        i_ll_done = 1'b1; i_ll_done_rd = 5'd20;
        step("frz_drain", mk(0, 0, 0, 0, 0));
        idle();

        // Reset mid-window with an op outstanding
        i_ll_issue = 1'b1; i_ll_rd = 5'd21;
        step("rst_pre_issue", mk(0, 0, 0, 0, 0));
        idle();
        i_br_taken = 1'b1;
        step("rst_pre_br", mk(0, 0, 0, 0, 1));
        idle();
        i_rst = 1'b1;
        step("rst_mid_window", mk(0, 0, 0, 0, 0));
        idle();
        i_id_rs1 = 5'd21; i_id_use1 = 1'b1; i_ll_done = 1'b1; i_ll_done_rd = 5'd21;
        step("rst_after_clean", mk(0, 0, 0, 0, 0));
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
